// File: rtl/synth_cfg_pkg.sv
// Shared synth configuration: decoder FSM states, bank indices, default map.
package synth_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    WAIT   = 3'd2,
    STROBE = 3'd3,
    HOLD   = 3'd4
  } state_t;

  localparam int BANK_ENV = 0;
  localparam int BANK_OSC = 1;
  localparam int BANK_M1  = 2;
  localparam int BANK_M2  = 3;
  localparam int BANK_COM = 5;

  localparam logic [7:0] DEF_BANK_MASK = 8'b0010_1111;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser plus rising-edge detector for async parser strobes.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_sync,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_edge;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_edge <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = o_sync & ~r_edge;

endmodule

// File: rtl/param_write_decoder.sv
// Sysex bank/parameter write decoder with delayed write strobe.
// Optional PWD_WRITE_ACK_EN: write held until wr_ack handshake.
module param_write_decoder
  import synth_cfg_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter logic [NUM_BANKS-1:0] BANK_MASK = NUM_BANKS'(DEF_BANK_MASK),
  parameter int ADR_W = 7,
  parameter int DATA_W = 8,
  parameter int SYNC_STAGES = 2,
  parameter int WR_DELAY = 2,
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 CLOCK_25,
  input  logic                 reset_reg,
  input  logic                 data_ready,
  input  logic [BANK_W-1:0]    bank_adr,
  input  logic [ADR_W-1:0]     param_adr,
  input  logic [DATA_W-1:0]    param_data,
`ifdef PWD_WRITE_ACK_EN
  input  logic                 wr_ack,
`endif
  output logic [NUM_BANKS-1:0] bank_sel,
  output logic                 write,
  output logic [ADR_W-1:0]     wr_adr,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 busy,
  output logic                 bank_err,
  output logic                 overrun
);

  localparam int MAP_W = 1 << BANK_W;
  // Zero-extended map: bank codes beyond NUM_BANKS read as unmapped
  localparam logic [MAP_W-1:0] MAP = MAP_W'(BANK_MASK);

  logic w_sync;
  logic w_rise;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk (CLOCK_25),
    .i_rst (reset_reg),
    .i_d   (data_ready),
    .o_sync(w_sync),
    .o_rise(w_rise)
  );

  state_t              r_state, w_state_n;
  logic [3:0]          r_cnt, w_cnt_n;
  logic [BANK_W-1:0]   r_cap_bank;
  logic [ADR_W-1:0]    r_cap_adr;
  logic [DATA_W-1:0]   r_cap_data;
  logic [NUM_BANKS-1:0] r_sel, w_sel_n;
  logic [ADR_W-1:0]    r_wadr, w_wadr_n;
  logic [DATA_W-1:0]   r_wdata, w_wdata_n;
  logic                r_write, w_write_n;
  logic                r_err, w_err_n;
  logic                r_ovr, w_ovr_n;
  logic                w_cap;
  logic                w_mapped;
  logic [NUM_BANKS-1:0] w_onehot;

  assign w_mapped = MAP[r_cap_bank];
  assign w_onehot = {{(NUM_BANKS-1){1'b0}}, 1'b1} << r_cap_bank;

  always_ff @(posedge CLOCK_25 or posedge reset_reg) begin
    if (reset_reg) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_cap_bank <= '0;
      r_cap_adr  <= '0;
      r_cap_data <= '0;
      r_sel      <= '0;
      r_wadr     <= '0;
      r_wdata    <= '0;
      r_write    <= 1'b0;
      r_err      <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      if (w_cap) begin
        r_cap_bank <= bank_adr;
        r_cap_adr  <= param_adr;
        r_cap_data <= param_data;
      end
      r_sel   <= w_sel_n;
      r_wadr  <= w_wadr_n;
      r_wdata <= w_wdata_n;
      r_write <= w_write_n;
      r_err   <= w_err_n;
      r_ovr   <= w_ovr_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_sel_n   = r_sel;
    w_wadr_n  = r_wadr;
    w_wdata_n = r_wdata;
    w_write_n = 1'b0;
    w_err_n   = 1'b0;
    w_cap     = 1'b0;
    w_ovr_n   = r_ovr | (w_rise & (r_state != IDLE));
    unique case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_cap     = 1'b1;
          w_state_n = DECODE;
        end
      end
      DECODE: begin
        if (w_mapped) begin
          w_sel_n   = w_onehot;
          w_wadr_n  = r_cap_adr;
          w_wdata_n = r_cap_data;
          w_cnt_n   = 4'(WR_DELAY - 1);
          w_state_n = WAIT;
        end else begin
          w_sel_n   = '0;
          w_err_n   = 1'b1;
          w_state_n = IDLE;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_write_n = 1'b1;
          w_state_n = STROBE;
        end else begin
          w_cnt_n = r_cnt - 4'd1;
        end
      end
      STROBE: begin
`ifdef PWD_WRITE_ACK_EN
        if (wr_ack) begin
          w_state_n = HOLD;
        end else begin
          w_write_n = 1'b1;
        end
`else
        w_state_n = HOLD;
`endif
      end
      HOLD: begin
        if (!w_sync) w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign bank_sel = r_sel;
  assign write    = r_write;
  assign wr_adr   = r_wadr;
  assign wr_data  = r_wdata;
  assign busy     = (r_state != IDLE);
  assign bank_err = r_err;
  assign overrun  = r_ovr;

endmodule

// File: doc/param_write_decoder.md
Name: param_write_decoder

Overview:
- Parametrised successor to the synth's sysex bank address decoder.
- Sits between the sysex parser and the parameter register banks (env, osc, m1, m2, com and later banks).
- Synchronises the parser's data_ready level, captures the bank, parameter address and data, and drives a one-hot bank select.
- Issues a delayed write strobe. The bank map, bank count, widths and timing are all parameters.
- Everything runs on one clock; no logic is clocked by data_ready.

Parameters:
- NUM_BANKS, 8, number of bank select outputs; BANK_W = $clog2(NUM_BANKS), derived.
- BANK_MASK, 8'b0010_1111, bit i set means bank i is mapped; default maps banks 0,1,2,3,5.
- ADR_W, 7, parameter address width.
- DATA_W, 8, parameter data width.
- SYNC_STAGES, 2, synchroniser depth for data_ready; legal range 2..4.
- WR_DELAY, 2, cycles from bank_sel valid to write assertion; legal range 1..15.

Ports:
- CLOCK_25  in  1  system clock.
- reset_reg  in  1  asynchronous reset, active-high.
- data_ready  in  1  level from sysex parser, asynchronous to CLOCK_25; rising edge starts a transaction.
- bank_adr  in  BANK_W  bank number, stable while data_ready is high.
- param_adr  in  ADR_W  parameter address within the bank.
- param_data  in  DATA_W  parameter value.
- bank_sel  out  NUM_BANKS  one-hot registered select.
- write  out  1  write strobe to the selected bank.
- wr_adr  out  ADR_W  captured address.
- wr_data  out  DATA_W  captured data.
- busy  out  1  high in any state other than IDLE.
- bank_err  out  1  one-cycle pulse when the bank is unmapped.
- overrun  out  1  sticky flag: a rising edge arrived while busy; cleared only by reset.
- wr_ack  in  1  present only with PWD_WRITE_ACK_EN.

Behaviour:
Reset (async, reset_reg=1):
- All outputs 0, FSM in IDLE.
- Synchroniser and edge-detect registers cleared.
- Delay counter cleared.

Synchroniser and edge detection:
- data_ready passes through SYNC_STAGES flops, then one edge register.
- rise = sync_out & ~edge_reg.

FSM states: IDLE, DECODE, WAIT, STROBE, HOLD.
- IDLE: on rise, capture bank_adr, param_adr and param_data into internal registers; go to DECODE.
- DECODE, bank mapped: bank_sel <= one-hot(bank); wr_adr and wr_data driven from the capture registers; counter <= WR_DELAY-1; go to WAIT.
- DECODE, bank unmapped (BANK_MASK bit 0, or bank >= NUM_BANKS): bank_sel <= 0; bank_err pulses one cycle; return to IDLE; no write.
- WAIT: decrement the counter; at 0 go to STROBE with write <= 1.
- STROBE: write is high exactly one cycle (without the macro); go to HOLD.
- HOLD: return to IDLE once sync_out == 0.
  - bank_sel, wr_adr and wr_data stay at their last values until the next DECODE, matching the latched-select behaviour the banks expect.

Latency:
- Count CLOCK_25 edges starting at the first edge that samples data_ready=1.
- busy rises after SYNC_STAGES+1 edges.
- bank_sel is valid after SYNC_STAGES+2 edges.
- write is high after SYNC_STAGES+2+WR_DELAY edges. With defaults this is 6.

Boundary conditions:
- Rising edge while busy: the transaction is dropped, overrun is set, and the captured values are unchanged.
- data_ready falls before STROBE: the transaction still completes; HOLD exits immediately.
- data_ready is still high after HOLD: no retrigger. A new transaction needs a fresh rising edge.
- Reset mid-transaction: write deasserts immediately and no partial write is issued.
- bank_adr changing after capture is ignored.

Optional Feature:
- Macro: PWD_WRITE_ACK_EN.
- With the macro:
  - wr_ack port exists.
  - In STROBE, write stays high until wr_ack is sampled 1; the cycle after, write=0 and the FSM moves to HOLD.
  - busy stays high throughout.
  - wr_ack high on the first STROBE cycle gives a one-cycle write.
- Without the macro:
  - No wr_ack port.
  - write is a fixed one-cycle pulse.

Decomposition:
- Shared package synth_cfg_pkg holds:
  - state enum typedef (IDLE, DECODE, WAIT, STROBE, HOLD);
  - localparam bank indices BANK_ENV=0, BANK_OSC=1, BANK_M1=2, BANK_M2=3, BANK_COM=5;
  - default BANK_MASK constant.
- One sub-module: sync_edge_det, parametrised by SYNC_STAGES. It is the synchroniser plus rising-edge detector and is reusable for other parser strobes.

Test Plan:
1. Reset then data_ready=1, bank_adr=1, param_adr=7'h12, param_data=8'h5A -> bank_sel=8'b0000_0010 after 4 edges; write high exactly at edge 6 for 1 cycle; wr_adr=12h, wr_data=5Ah.
2. bank_adr=4 (unmapped) -> bank_err one pulse at edge 4; bank_sel=0; no write; busy low at edge 5.
3. Second rising edge 2 cycles after the first (while busy) -> overrun=1 and stays 1; first write completes with the original data; no second write.
4. reset_reg pulsed during WAIT -> write never asserts; all outputs 0 at once; a following transaction to bank 5 gives bank_sel=8'b0010_0000 with normal latency.
5. data_ready held high for 20 cycles -> exactly one write; bank_sel held at bank 0 value after return to IDLE until the next transaction.
6. With PWD_WRITE_ACK_EN, wr_ack raised 3 cycles after write -> write high for 4 cycles; busy high until HOLD exit.
